// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU front end and its
// combinational execution unit.
package alu_pkg;

    localparam int MAX_LAT = 15;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic SEL_ARITH = 1'b0;
    localparam logic SEL_LOGIC = 1'b1;

    typedef enum logic [1:0] {add, sub, mul, div} arith_operation;
    typedef enum logic [1:0] {nand_op, nor_op, not_op, xor_op} logic_operation;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

    typedef struct packed {
        logic       sel;
        logic [1:0] operation;
        logic [7:0] data1;
        logic [7:0] data2;
    } alu_cmd_t;

    // Execute cycles L for a command; only mul and div take longer than one.
    function automatic logic [CNT_W-1:0] exec_cycles(input alu_cmd_t cmd,
                                                     input logic [CNT_W-1:0] mul_lat,
                                                     input logic [CNT_W-1:0] div_lat);
        exec_cycles = CNT_W'(1);
        if (cmd.sel == SEL_ARITH) begin
            if (cmd.operation == mul)
                exec_cycles = mul_lat;
            else if (cmd.operation == div)
                exec_cycles = div_lat;
        end
    endfunction

endpackage

// File: rtl/alu_exec_unit.sv
// Purely combinational 8-bit arithmetic/logic datapath producing a 16-bit result.
module alu_exec_unit
    import alu_pkg::*;
(
    input  alu_cmd_t    cmd,
    output logic [15:0] result
);

    always_comb begin
        // NOTE: default assignment first so every path drives result and no latch is inferred.
        result = 16'h0000;
        if (cmd.sel == SEL_ARITH) begin
            case (arith_operation'(cmd.operation))
                add: result = {7'b0, {1'b0, cmd.data1} + {1'b0, cmd.data2}};
                sub: result = {8'b0, cmd.data1} - {8'b0, cmd.data2};
                mul: result = {8'b0, cmd.data1} * {8'b0, cmd.data2};
                div: begin
                    if (cmd.data2 == 8'h00)
                        result = 16'hFFFF;
                    else
                        result = {cmd.data1 % cmd.data2, cmd.data1 / cmd.data2};
                end
                default: result = 16'h0000;
            endcase
        end else begin
            case (logic_operation'(cmd.operation))
                nand_op: result = {8'h00, ~(cmd.data1 & cmd.data2)};
                nor_op:  result = {8'h00, ~(cmd.data1 | cmd.data2)};
                not_op:  result = {8'h00, ~cmd.data1};
                xor_op:  result = {8'h00, cmd.data1 ^ cmd.data2};
                default: result = 16'h0000;
            endcase
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin front end: grants one of two requesters, runs the op for its
// fixed latency on the shared execution unit, then holds the response until taken.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int DIV_LAT = 4,
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic        req0_arith_logic_sel,
    input  logic [1:0]  req0_operation,
    input  logic [7:0]  req0_data1,
    input  logic [7:0]  req0_data2,
    input  logic        req1_arith_logic_sel,
    input  logic [1:0]  req1_operation,
    input  logic [7:0]  req1_data1,
    input  logic [7:0]  req1_data2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        busy
);

    localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_LAT);

    arb_state_t       state, state_next;
    alu_cmd_t         cmd0, cmd1, cmd_q, cmd_sel;
    logic             grant, id_q, last_grant;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      exec_data;

    assign cmd0 = '{sel: req0_arith_logic_sel, operation: req0_operation,
                    data1: req0_data1, data2: req0_data2};
    assign cmd1 = '{sel: req1_arith_logic_sel, operation: req1_operation,
                    data1: req1_data1, data2: req1_data2};

    // A lone requester always wins; on a tie the one not served last wins.
    assign grant   = req_valid[1] & (~req_valid[0] | ~last_grant);
    assign cmd_sel = grant ? cmd1 : cmd0;

    alu_exec_unit u_exec (
        .cmd    (cmd_q),
        .result (exec_data)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (|req_valid) state_next = EXEC;
            EXEC:    if (cnt == '0)  state_next = RESP;
            RESP:    if (rsp_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && !rst && |req_valid)
            req_ready[grant] = 1'b1;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            id_q       <= 1'b0;
            cnt        <= '0;
            rsp_data   <= 16'h0000;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        cmd_q <= cmd_sel;
                        id_q  <= grant;
                        cnt   <= exec_cycles(cmd_sel, MUL_L, DIV_L) - CNT_W'(1);
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_data <= exec_data;
                        rsp_id   <= id_q;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: if (rsp_ready) last_grant <= rsp_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: a vector table of single-requester ops
// plus hand-written sequences for ties, back-pressure and mid-op reset.
module tb_alu_req_arbiter;

    localparam int DIV_LAT = 4;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        req0_arith_logic_sel, req1_arith_logic_sel;
    logic [1:0]  req0_operation, req1_operation;
    logic [7:0]  req0_data1, req0_data2, req1_data1, req1_data2;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rsp_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.DIV_LAT(DIV_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req0_arith_logic_sel (req0_arith_logic_sel),
        .req0_operation       (req0_operation),
        .req0_data1           (req0_data1),
        .req0_data2           (req0_data2),
        .req1_arith_logic_sel (req1_arith_logic_sel),
        .req1_operation       (req1_operation),
        .req1_data1           (req1_data1),
        .req1_data2           (req1_data2),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_id               (rsp_id),
        .rsp_data             (rsp_data),
        .busy                 (busy)
    );

    typedef struct {
        logic        id;
        logic        sel;
        logic [1:0]  op;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [15:0] exp;
        int          cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic set_cmd(input logic id, input logic sel, input logic [1:0] op,
                           input logic [7:0] d1, input logic [7:0] d2);
        if (id == 1'b0) begin
            req0_arith_logic_sel = sel; req0_operation = op;
            req0_data1 = d1; req0_data2 = d2;
        end else begin
            req1_arith_logic_sel = sel; req1_operation = op;
            req1_data1 = d1; req1_data2 = d2;
        end
    endtask

    // Called just after the accept edge. Counts falling edges until rsp_valid;
    // on the first one drops/scrambles the requesters in 'drop' to prove capture.
    task automatic wait_rsp(input string name, input logic [15:0] exp_data,
                            input logic exp_id, input int exp_cyc, input logic [1:0] drop);
        int n = 0;
        bit seen = 0;
        bit ready_ok = 1;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                req_valid = req_valid & ~drop;
                if (drop[0]) begin
                    req0_data1 = 8'h00; req0_data2 = 8'h00; req0_operation = ~req0_operation;
                end
                if (drop[1]) begin
                    req1_data1 = 8'h00; req1_data2 = 8'h00; req1_operation = ~req1_operation;
                end
                #1;
            end
            if (req_ready != 2'b00) ready_ok = 0;
            if (rsp_valid) seen = 1;
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        check({name, "_cycles"}, 32'(n), 32'(exp_cyc));
        check({name, "_data"}, {16'h0, rsp_data}, {16'h0, exp_data});
        check({name, "_id"}, 32'(rsp_id), 32'(exp_id));
        check({name, "_ready_low"}, 32'(ready_ok), 32'd1);
    endtask

    initial begin
        // Single-requester vectors: {id, sel, op, d1, d2, expected, cycles = L+1}
        vecs[0]  = '{1'b0, 1'b0, 2'd0, 8'hFF, 8'h01, 16'h0100, 2};
        vecs[1]  = '{1'b1, 1'b0, 2'd3, 8'd200, 8'd7, 16'h041C, DIV_LAT + 1};
        vecs[2]  = '{1'b1, 1'b0, 2'd3, 8'd9, 8'd0, 16'hFFFF, DIV_LAT + 1};
        vecs[3]  = '{1'b0, 1'b0, 2'd2, 8'h10, 8'h10, 16'h0100, MUL_LAT + 1};
        vecs[4]  = '{1'b0, 1'b0, 2'd1, 8'd3, 8'd5, 16'hFFFE, 2};
        vecs[5]  = '{1'b1, 1'b1, 2'd0, 8'hA5, 8'h0F, 16'h00FA, 2};
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 8'hF0, 8'h0C, 16'h0003, 2};
        vecs[7]  = '{1'b1, 1'b1, 2'd2, 8'h5A, 8'hFF, 16'h00A5, 2};
        vecs[8]  = '{1'b0, 1'b1, 2'd3, 8'hF0, 8'h3C, 16'h00CC, 2};
        vecs[9]  = '{1'b1, 1'b0, 2'd2, 8'hFF, 8'hFF, 16'hFE01, MUL_LAT + 1};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 8'h7F, 8'h01, 16'h0080, 2};
        vecs[11] = '{1'b1, 1'b0, 2'd1, 8'd200, 8'd100, 16'h0064, 2};

        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        set_cmd(1'b0, 1'b0, 2'd2, 8'h10, 8'h10);
        set_cmd(1'b1, 1'b1, 2'd3, 8'hF0, 8'h3C);
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", {16'h0, rsp_data}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Tie at reset release: req0 first, then req1, then req0 again.
        @(negedge clk);
        rst = 1'b0;
        #1 check("tie_first_grant", 32'(req_ready), 32'b01);
        @(posedge clk);
        wait_rsp("tie_mul", 16'h0100, 1'b0, MUL_LAT + 1, 2'b01);
        @(negedge clk);
        #1 check("tie_second_grant", 32'(req_ready), 32'b10);
        @(posedge clk);
        wait_rsp("tie_xor", 16'h00CC, 1'b1, 2, 2'b10);
        @(negedge clk);
        req_valid = 2'b11;
        #1 check("tie_third_grant", 32'(req_ready), 32'b01);
        req_valid = 2'b00;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_cmd(vecs[i].id, vecs[i].sel, vecs[i].op, vecs[i].d1, vecs[i].d2);
            req_valid = vecs[i].id ? 2'b10 : 2'b01;
            #1 check($sformatf("vec%0d_accept", i), 32'(req_ready), 32'(req_valid));
            @(posedge clk);
            wait_rsp($sformatf("vec%0d", i), vecs[i].exp, vecs[i].id, vecs[i].cyc, req_valid);
        end

        // Back-pressure: result held for 10 cycles with req1 waiting.
        begin
            bit hold_ok = 1;
            int n = 0;
            @(negedge clk);
            rsp_ready = 1'b0;
            set_cmd(1'b0, 1'b0, 2'd1, 8'd3, 8'd5);
            req_valid = 2'b01;
            #1 check("bp_accept", 32'(req_ready), 32'b01);
            @(posedge clk);
            @(negedge clk);
            req_valid = 2'b10;
            set_cmd(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
            while (!rsp_valid && n < 32) begin
                @(negedge clk);
                n++;
            end
            check("bp_seen", 32'(rsp_valid), 32'd1);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_data !== 16'hFFFE || rsp_id !== 1'b0 || req_ready !== 2'b00)
                    hold_ok = 0;
            end
            check("bp_hold_stable", 32'(hold_ok), 32'd1);
            check("bp_data", {16'h0, rsp_data}, 32'h0000FFFE);
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            #1;
            check("bp_done_valid", 32'(rsp_valid), 32'd0);
            check("bp_done_busy", 32'(busy), 32'd0);
            check("bp_req1_grant", 32'(req_ready), 32'b10);
            req_valid = 2'b00;
        end

        // Reset during div EXEC: no response, and the tie pointer returns to req0.
        begin
            bit quiet = 1;
            @(negedge clk);
            set_cmd(1'b1, 1'b0, 2'd3, 8'd50, 8'd5);
            req_valid = 2'b10;
            #1 check("rst_div_accept", 32'(req_ready), 32'b10);
            @(posedge clk);
            @(negedge clk);
            req_valid = 2'b00;
            check("rst_div_busy", 32'(busy), 32'd1);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            #1;
            check("mid_rst_busy", 32'(busy), 32'd0);
            check("mid_rst_valid", 32'(rsp_valid), 32'd0);
            check("mid_rst_ready", 32'(req_ready), 32'd0);
            check("mid_rst_data", {16'h0, rsp_data}, 32'd0);
            rst = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (rsp_valid || busy) quiet = 0;
            end
            check("mid_rst_no_rsp", 32'(quiet), 32'd1);
            req_valid = 2'b11;
            #1 check("mid_rst_tie", 32'(req_ready), 32'b01);
            req_valid = 2'b00;
        end

        // Both continuously valid: grants alternate 0,1,0,1...
        set_cmd(1'b0, 1'b1, 2'd2, 8'h5A, 8'hFF);
        set_cmd(1'b1, 1'b0, 2'd0, 8'h12, 8'h34);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = 2'b11;
            #1 check($sformatf("alt%0d_grant", i), 32'(req_ready), (i % 2) ? 32'b10 : 32'b01);
            @(posedge clk);
            if (i % 2 == 0)
                wait_rsp($sformatf("alt%0d", i), 16'h00A5, 1'b0, 2, 2'b00);
            else
                wait_rsp($sformatf("alt%0d", i), 16'h0046, 1'b1, 2, 2'b00);
        end
        req_valid = 2'b00;

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
